store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the M-stage store path and the data memory. Stores are accepted, held in a small in-order FIFO, and drained to DM one per cycle on DM's `DMWr/DMType/addr/WD/pc` port. Loads that read a word with a store still pending get a hazard flag, so the pipeline stalls instead of reading stale data. Misaligned or non-store requests are rejected and latched into a sticky error flag.

## Interface
- `DEPTH`, 4: entry count; power of two, 2..16.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `st_valid`  in  1  store request this cycle.
- `st_ready`  out  1  buffer can accept; equals !full.
- `st_pc`  in  32  PC of the store; carried to DM for its write trace.
- `st_addr`  in  32  byte address.
- `st_type`  in  3  `DM_w` / `DM_h` / `DM_b` (const.v encoding).
- `st_data`  in  32  store data, right-aligned as DM expects in `WD`.
- `ld_valid`  in  1  M-stage load present.
- `ld_addr`  in  32  load byte address.
- `ld_hazard`  out  1  combinational; load word matches a pending store.
- `dm_stall`  in  1  DM port unavailable this cycle; no drain.
- `dm_wr`  out  1  to DM `DMWr`.
- `dm_type`  out  3  to DM `DMType`.
- `dm_addr`  out  32  to DM `addr`.
- `dm_wd`  out  32  to DM `WD`.
- `dm_pc`  out  32  to DM `pc`.
- `count`  out  clog2(DEPTH+1)  valid entries.
- `empty`  out  1  count==0.
- `align_err`  out  1  sticky reject flag.

## Operation
- Entry fields: pc, addr, type, data. Circular buffer with head/tail pointers of width log2(DEPTH). Pointers wrap modulo DEPTH.
- Push at a clock edge when `st_valid && st_ready` and the request is legal.
- A request is legal when `st_type` is `DM_w` with addr[1:0]==0, `DM_h` with addr[0]==0, or `DM_b` with any address.
- An illegal accepted request (`DM_hu`, `DM_bu`, other codes, or misaligned) is consumed but not enqueued. `align_err` sets to 1 and holds until reset.
- Drain: `dm_wr = !empty && !dm_stall`.
  - `dm_type/dm_addr/dm_wd/dm_pc` are driven combinationally from the head entry.
  - All dm outputs are zero when empty.
  - The head pops at the same edge where DM commits the write.
- Stores drain strictly in acceptance order. No merging, no reordering.
- `ld_hazard = ld_valid && (some valid entry has addr[31:2] == ld_addr[31:2])`.
  - The head being drained this cycle still counts.
  - A store being pushed this cycle does not count.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full: `st_ready`=0 even if a pop occurs this cycle (no same-cycle pass-through).
- Reset asserted mid-operation: all entries invalidated, pending stores discarded, never written to DM.

## Timing
- Reset values:
  - `st_ready`=1, `empty`=1.
  - `count`=0, `align_err`=0.
  - `dm_wr`=0, `dm_type/dm_addr/dm_wd/dm_pc`=0.
  - `ld_hazard`=0.
- Store latency: pushed at edge N → `dm_wr`=1 in cycle N..N+1 (if no `dm_stall`) → DM commits at edge N+1.
- Throughput: one push and one drain per cycle.
- `dm_stall` high holds the head unchanged; the entry drains on the first cycle `dm_stall` is low.
- `ld_hazard`, `dm_*`, `st_ready` and `empty` are combinational from registered state and inputs; there are no combinational paths from `st_*` inputs to `dm_*` outputs.
- The pipeline holds its load while `ld_hazard`=1. The hazard clears in the cycle after the last matching entry pops.

## Structure
- `DM_w/DM_h/DM_hu/DM_b/DM_bu` encodings come from const.v. No new codes.
- Add to const.v: `SB_DEPTH` default 4.
- One sub-module: `sb_addr_match`, a DEPTH-wide parallel word-address comparator. It takes the valid mask and the entry addresses and returns any-match. Everything else lives in `store_buffer`.

## Test plan
- Single store, then drain:
  - Stimulus: `DM_w` at 0x0000_0010, data 0xDEADBEEF, pc 0x3000.
  - Required: `dm_wr`=1 the next cycle with `dm_addr`=0x10, `dm_wd`=0xDEADBEEF, `dm_pc`=0x3000; `empty`=1 after that edge.
- Fill and wrap:
  - Stimulus: 4 stores pushed with `dm_stall`=1.
  - Required: `count`=4, `st_ready`=0, a fifth push is ignored. Release the stall and push 2 more.
  - Required: 6 writes in push order, count back to 0.
- Load hazard:
  - Stimulus: `DM_b` pending at 0x23; load at 0x20.
  - Required: `ld_hazard`=1. A load at 0x24 → 0. Hazard drops the cycle after the 0x23 entry pops.
- Illegal stores:
  - Stimulus: `DM_h` at 0x11, `DM_w` at 0x02, `DM_bu` at 0x00.
  - Required: nothing enqueued, `count`=0, `align_err`=1 until reset.
- Simultaneous push and pop at count=2:
  - Required: `count` stays 2 and order is preserved.
- Reset mid-drain:
  - Stimulus: 3 entries pending; `reset`=0 asynchronously mid-cycle.
  - Required: `dm_wr` drops to 0 immediately and `count`=0; no write reaches DM after release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared DM access-type encodings, buffer depth default,
// entry layout and the store legality rule used by the store buffer.
package store_buffer_pkg;

  // DM access types (const.v encoding)
  localparam logic [2:0] DM_w  = 3'b000;
  localparam logic [2:0] DM_h  = 3'b001;
  localparam logic [2:0] DM_hu = 3'b010;
  localparam logic [2:0] DM_b  = 3'b011;
  localparam logic [2:0] DM_bu = 3'b100;

  localparam int unsigned SB_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [2:0]  dtype;
    logic [31:0] data;
  } sb_entry_t;

  // Only naturally aligned w/h/b stores may be buffered.
  function automatic logic sb_legal(input logic [2:0] t, input logic [1:0] a);
    case (t)
      DM_w:    return (a == 2'b00);
      DM_h:    return !a[0];
      DM_b:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sb_addr_match.sv
// sb_addr_match: DEPTH-wide parallel word-address comparator.
//   valid_mask  : per-entry valid bits
//   entry_words : packed entry word addresses (addr[31:2]), entry i at [i*30 +: 30]
//   ld_word     : load word address (ld_addr[31:2])
//   any_match   : some valid entry holds the same word
module sb_addr_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic [DEPTH-1:0]    valid_mask,
  input  logic [DEPTH*30-1:0] entry_words,
  input  logic [29:0]         ld_word,
  output logic                any_match
);

  always_comb begin
    any_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_mask[i] && (entry_words[i*30 +: 30] == ld_word)) begin
        any_match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the M-stage store path and DM.
//   st_*      : store request in (st_ready = !full)
//   ld_*      : M-stage load probe, ld_hazard when its word is still pending
//   dm_stall  : DM busy, hold head
//   dm_*      : head entry driven to DM, dm_wr = !empty && !dm_stall
//   count/empty/align_err : occupancy and sticky illegal-request flag
//   reset     : asynchronous, active-low
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [31:0]                  st_pc,
  input  logic [31:0]                  st_addr,
  input  logic [2:0]                   st_type,
  input  logic [31:0]                  st_data,
  input  logic                         ld_valid,
  input  logic [31:0]                  ld_addr,
  output logic                         ld_hazard,
  input  logic                         dm_stall,
  output logic                         dm_wr,
  output logic [2:0]                   dm_type,
  output logic [31:0]                  dm_addr,
  output logic [31:0]                  dm_wd,
  output logic [31:0]                  dm_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         align_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  sb_entry_t        mem_q [DEPTH];
  sb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             align_err_q, align_err_d;

  logic             full, push_req, push, pop;
  logic [DEPTH*30-1:0] entry_words;
  logic             any_match;
  sb_entry_t        head_e;
  logic             unused_ld_lsb;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    push_req = st_valid && !full;
    push     = push_req && sb_legal(st_type, st_addr[1:0]);
    pop      = (count_q != '0) && !dm_stall;

    head_d      = head_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    mem_d       = mem_q;
    align_err_d = align_err_q | (push_req && !push);

    // Pop before push: with 0 < count < DEPTH head and tail never alias.
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      mem_d[tail_q]   = '{pc: st_pc, addr: st_addr, dtype: st_type, data: st_data};
      tail_d          = tail_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      align_err_q <= align_err_d;
    end
  end

  // Payload needs no reset; it is only observed through valid/count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    entry_words = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_words[i*30 +: 30] = mem_q[i].addr[31:2];
    end
  end

  sb_addr_match #(.DEPTH(DEPTH)) u_match (
    .valid_mask  (valid_q),
    .entry_words (entry_words),
    .ld_word     (ld_addr[31:2]),
    .any_match   (any_match)
  );

  // Byte offset of a load is irrelevant to word-granular hazard detection.
  assign unused_ld_lsb = ^ld_addr[1:0];

  always_comb begin
    head_e    = mem_q[head_q];
    empty     = (count_q == '0);
    st_ready  = !full;
    dm_wr     = pop;
    dm_type   = empty ? '0 : head_e.dtype;
    dm_addr   = empty ? '0 : head_e.addr;
    dm_wd     = empty ? '0 : head_e.data;
    dm_pc     = empty ? '0 : head_e.pc;
    ld_hazard = ld_valid && any_match;
    count     = count_q;
    align_err = align_err_q;
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_pc, st_addr, st_data;
  logic [2:0]  st_type;
  logic        ld_valid, ld_hazard;
  logic [31:0] ld_addr;
  logic        dm_stall, dm_wr;
  logic [2:0]  dm_type;
  logic [31:0] dm_addr, dm_wd, dm_pc;
  logic [2:0]  count;
  logic        empty, align_err;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_pc(st_pc), .st_addr(st_addr),
    .st_type(st_type), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .dm_stall(dm_stall), .dm_wr(dm_wr), .dm_type(dm_type), .dm_addr(dm_addr),
    .dm_wd(dm_wd), .dm_pc(dm_pc),
    .count(count), .empty(empty), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [2:0]  t;
    logic [31:0] data;
  } ent_t;

  ent_t model_q[$];   // reference buffer contents
  ent_t exp_q[$];     // scoreboard of writes DM must see, in order
  bit   model_err;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] t, input logic [31:0] a);
    if (t == DM_w) return (a % 4) == 0;
    if (t == DM_h) return (a % 2) == 0;
    if (t == DM_b) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every committed DM write must be the oldest outstanding store.
  always @(negedge clk) begin : mon
    ent_t e;
    if (rst_n && dm_wr) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h expected no write", dm_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", dm_addr, e.addr);
        chk("wr_data", dm_wd, e.data);
        chk("wr_pc", dm_pc, e.pc);
        chk("wr_type", {29'd0, dm_type}, {29'd0, e.t});
      end
    end
  end

  // One clock cycle: apply inputs, check combinational outputs, advance model.
  task automatic cycle(input bit sv, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [2:0] t, input logic [31:0] d,
                       input bit lv, input logic [31:0] la, input bit stall);
    int  sz;
    bit  hz, acc;
    ent_t e;
    st_valid = sv; st_pc = pc; st_addr = addr; st_type = t; st_data = d;
    ld_valid = lv; ld_addr = la; dm_stall = stall;
    @(negedge clk);
    sz = model_q.size();
    hz = 1'b0;
    foreach (model_q[i]) if ((model_q[i].addr >> 2) == (la >> 2)) hz = 1'b1;
    hz = hz && lv;
    chk("count", {29'd0, count}, sz);
    chk("empty", {31'd0, empty}, {31'd0, sz == 0});
    chk("st_ready", {31'd0, st_ready}, {31'd0, sz < DEPTH});
    chk("align_err", {31'd0, align_err}, {31'd0, model_err});
    chk("ld_hazard", {31'd0, ld_hazard}, {31'd0, hz});
    chk("dm_wr", {31'd0, dm_wr}, {31'd0, (sz > 0) && !stall});
    if (sz == 0) begin
      chk("idle_dm_addr", dm_addr, 32'd0);
      chk("idle_dm_wd", dm_wd, 32'd0);
      chk("idle_dm_pc", dm_pc, 32'd0);
      chk("idle_dm_type", {29'd0, dm_type}, 32'd0);
    end
    @(posedge clk);
    acc = sv && (sz < DEPTH);
    if (sz > 0 && !stall) void'(model_q.pop_front());
    if (acc) begin
      if (legal(t, addr)) begin
        e = '{pc: pc, addr: addr, t: t, data: d};
        model_q.push_back(e);
        exp_q.push_back(e);
      end else begin
        model_err = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input bit stall);
    cycle(1'b0, 32'd0, 32'd0, DM_w, 32'd0, 1'b0, 32'd0, stall);
  endtask

  task automatic store(input logic [31:0] addr, input logic [2:0] t, input bit stall);
    cycle(1'b1, 32'h4000 + addr, addr, t, $urandom, 1'b0, 32'd0, stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    logic [2:0]  rt;
    logic [31:0] ra;
    model_err = 1'b0;
    rst_n = 1'b0;
    st_valid = 1'b0; st_pc = '0; st_addr = '0; st_type = DM_w; st_data = '0;
    ld_valid = 1'b1; ld_addr = 32'd0; dm_stall = 1'b0;
    #2;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_align_err", {31'd0, align_err}, 32'd0);
    chk("rst_dm_wr", {31'd0, dm_wr}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_ld_hazard", {31'd0, ld_hazard}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single store then drain
    cycle(1'b1, 32'h3000, 32'h10, DM_w, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
    chk("single_dm_addr", dm_addr, 32'h10);
    chk("single_dm_wd", dm_wd, 32'hDEADBEEF);
    chk("single_dm_pc", dm_pc, 32'h3000);
    idle(1'b0);
    chk("single_empty", {31'd0, empty}, 32'd1);

    // Fill under stall, overflow attempt, then release and push two more
    w0 = n_writes;
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(i) * 4, DM_w, 1'b1);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ready", {31'd0, st_ready}, 32'd0);
    store(32'h200, DM_w, 1'b1);            // ignored: full
    idle(1'b0);
    store(32'h110, DM_h, 1'b0);
    store(32'h115, DM_b, 1'b0);
    for (int i = 0; i < 10 && model_q.size() > 0; i++) idle(1'b0);
    chk("fill_writes", n_writes - w0, 32'd6);
    chk("fill_count", {29'd0, count}, 32'd0);

    // Load hazard: byte store at 0x23 vs loads at 0x20 / 0x24
    store(32'h23, DM_b, 1'b1);
    cycle(1'b0, 0, 0, DM_w, 0, 1'b1, 32'h20, 1'b1);
    cycle(1'b0, 0, 0, DM_w, 0, 1'b1, 32'h24, 1'b1);
    cycle(1'b0, 0, 0, DM_w, 0, 1'b1, 32'h20, 1'b0);   // draining, still hazard
    cycle(1'b0, 0, 0, DM_w, 0, 1'b1, 32'h20, 1'b0);   // cleared

    // Simultaneous push and pop at count 2
    store(32'h40, DM_w, 1'b1);
    store(32'h44, DM_w, 1'b1);
    store(32'h48, DM_w, 1'b0);
    store(32'h4C, DM_w, 1'b0);
    chk("pushpop_count", {29'd0, count}, 32'd2);
    for (int i = 0; i < 6 && model_q.size() > 0; i++) idle(1'b0);

    // Illegal stores
    store(32'h11, DM_h, 1'b0);
    store(32'h02, DM_w, 1'b0);
    store(32'h00, DM_bu, 1'b0);
    chk("illegal_count", {29'd0, count}, 32'd0);
    chk("illegal_err", {31'd0, align_err}, 32'd1);
    idle(1'b0);

    // Reset mid-drain with 3 entries pending
    for (int i = 0; i < 3; i++) store(32'h80 + 32'(i) * 4, DM_w, 1'b1);
    st_valid = 1'b0; dm_stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dm_wr", {31'd0, dm_wr}, 32'd0);
    chk("midrst_count", {29'd0, count}, 32'd0);
    chk("midrst_align_err", {31'd0, align_err}, 32'd0);
    model_q.delete();
    exp_q.delete();
    model_err = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: begin rt = DM_w; ra = 32'($urandom_range(0, 15)) * 4; end
        1: begin rt = DM_h; ra = 32'($urandom_range(0, 31)) * 2; end
        default: begin rt = DM_b; ra = 32'($urandom_range(0, 63)); end
      endcase
      if (i > 200 && $urandom_range(0, 19) == 0) begin
        rt = 3'($urandom_range(0, 7));
        ra = 32'($urandom_range(0, 63));
      end
      cycle($urandom_range(0, 1) == 1, $urandom, ra, rt, $urandom,
            $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)),
            $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 20 && model_q.size() > 0; i++) idle(1'b0);
    chk("final_count", {29'd0, count}, 32'd0);
    chk("final_outstanding", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
